// File: rtl/acc_req_queue.sv
// Per-core buffer of pending accumulate requests: one FIFO per shared accumulator, each head
// offered to the parent arbiter together with the global-counter stamp captured at enqueue.
module acc_req_queue #(
   parameter  int N_ACC    = 3,
   parameter  int DEPTH    = 4,
   parameter  int GC_WIDTH = 8,
   localparam int AW       = (N_ACC > 1) ? $clog2(N_ACC) : 1,
   localparam int PW       = $clog2(DEPTH),
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enq_valid,
   input  logic [AW-1:0]       enq_acc,
   input  logic [31:0]         enq_data,
   input  logic [GC_WIDTH-1:0] gc,
   output logic                enq_ready,
   output logic [N_ACC-1:0]    acc_req_valid,
   input  logic [N_ACC-1:0]    acc_req_ready,
   output logic [31:0]         acc_data [N_ACC],
   output logic [GC_WIDTH-1:0] gc_stamp [N_ACC],
   output logic                empty,
   output logic [CW-1:0]       count [N_ACC]
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // valid never depends on ready; enq_ready depends only on enq_acc and registered occupancy,
   // so a full FIFO refuses an enqueue even in a cycle where its head is being accepted.

   logic [N_ACC-1:0] enq_hit;
   logic [N_ACC-1:0] full;
   logic [N_ACC-1:0] enq_fire;
   logic [N_ACC-1:0] deq_fire;

   always_comb begin
      enq_hit  = '0;
      full     = '0;
      enq_fire = '0;
      deq_fire = '0;
      for (int i = 0; i < N_ACC; i++) begin
         enq_hit[i]  = (enq_acc == AW'(i));
         full[i]     = (count[i] == CW'(DEPTH));
         enq_fire[i] = enq_valid && enq_hit[i] && !full[i];
         deq_fire[i] = acc_req_valid[i] && acc_req_ready[i];
      end
   end

   // An out-of-range enq_acc matches no FIFO, so it is never ready and changes nothing.
   assign enq_ready = |(enq_hit & ~full);
   assign empty     = ~|acc_req_valid;

   for (genvar g = 0; g < N_ACC; g++) begin : g_fifo
      logic [31:0]         data_mem  [DEPTH];
      logic [GC_WIDTH-1:0] stamp_mem [DEPTH];
      logic [PW-1:0]       wr_ptr;
      logic [PW-1:0]       rd_ptr;
      logic [CW-1:0]       cnt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (enq_fire[g]) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire[g]) rd_ptr <= rd_ptr + PW'(1);
            case ({enq_fire[g], deq_fire[g]})
               2'b10:   cnt <= cnt + CW'(1);
               2'b01:   cnt <= cnt - CW'(1);
               default: cnt <= cnt;
            endcase
         end
      end

      // Storage carries no reset; the output gating below hides stale contents.
      always_ff @(posedge clk) begin
         if (enq_fire[g]) begin
            data_mem[wr_ptr]  <= enq_data;
            stamp_mem[wr_ptr] <= gc;
         end
      end

      assign count[g]         = cnt;
      assign acc_req_valid[g] = (cnt != '0);
      assign acc_data[g]      = acc_req_valid[g] ? data_mem[rd_ptr]  : '0;
      assign gc_stamp[g]      = acc_req_valid[g] ? stamp_mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_acc_req_queue.sv
// Directed bench for acc_req_queue: a per-FIFO expected queue is filled on accepted enqueues
// and a monitor pops and compares on every head handshake.
module tb_acc_req_queue;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enq_valid;
   logic [1:0]  enq_acc;
   logic [31:0] enq_data;
   logic [7:0]  gc;
   logic        enq_ready;
   logic [2:0]  acc_req_valid;
   logic [2:0]  acc_req_ready;
   logic [31:0] acc_data [N];
   logic [7:0]  gc_stamp [N];
   logic        empty;
   logic [2:0]  count [N];

   int total = 0;
   int bad   = 0;
   logic [39:0] exp_q [N][$];

   acc_req_queue #(.N_ACC(3), .DEPTH(4), .GC_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_acc(enq_acc),
      .enq_data(enq_data), .gc(gc), .enq_ready(enq_ready),
      .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready),
      .acc_data(acc_data), .gc_stamp(gc_stamp), .empty(empty), .count(count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int i = 0; i < N; i++) begin
            if (acc_req_valid[i] && acc_req_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("unexpected_head%0d", i), {24'd0, acc_data[i], gc_stamp[i]}, 64'd0);
               end else begin
                  logic [39:0] e;
                  e = exp_q[i].pop_front();
                  chk($sformatf("head_data%0d", i), 64'(acc_data[i]), 64'(e[39:8]));
                  chk($sformatf("head_stamp%0d", i), 64'(gc_stamp[i]), 64'(e[7:0]));
               end
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input int acc, input logic [31:0] d, input logic [7:0] g, input logic exp_rdy);
      enq_valid = 1'b1;
      enq_acc   = 2'(acc);
      enq_data  = d;
      gc        = g;
      @(negedge clk);
      chk($sformatf("enq_ready_acc%0d", acc), 64'(enq_ready), 64'(exp_rdy));
      if (exp_rdy && acc < N) exp_q[acc].push_back({d, g});
      step();
      enq_valid = 1'b0;
   endtask

   task automatic drain(input logic [2:0] mask, input int n);
      acc_req_ready = mask;
      repeat (n) step();
      acc_req_ready = 3'b000;
   endtask

   initial begin
      reset = 1'b1;
      enq_valid = 1'b0;
      enq_acc = 2'd0;
      enq_data = 32'd0;
      gc = 8'd0;
      acc_req_ready = 3'b000;
      repeat (2) @(posedge clk);
      #1;

      // T1 reset state
      chk("rst_valid", 64'(acc_req_valid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_enq_ready", 64'(enq_ready), 64'd1);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_data%0d", i), 64'(acc_data[i]), 64'd0);
         chk($sformatf("rst_stamp%0d", i), 64'(gc_stamp[i]), 64'd0);
         chk($sformatf("rst_count%0d", i), 64'(count[i]), 64'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      step();

      // illegal accumulator index is never ready and changes nothing
      enq(3, 32'hDEADBEEF, 8'd1, 1'b0);
      chk("illegal_empty", 64'(empty), 64'd1);

      // T2 single request, 1-cycle visibility, then accepted
      enq_valid = 1'b1; enq_acc = 2'd1; enq_data = 32'h3F800000; gc = 8'd5;
      @(negedge clk);
      chk("t2_enq_ready", 64'(enq_ready), 64'd1);
      chk("t2_no_bypass", 64'(acc_req_valid), 64'd0);
      exp_q[1].push_back({32'h3F800000, 8'd5});
      step();
      enq_valid = 1'b0;
      chk("t2_valid", 64'(acc_req_valid), 64'b010);
      chk("t2_data", 64'(acc_data[1]), 64'h3F800000);
      chk("t2_stamp", 64'(gc_stamp[1]), 64'd5);
      chk("t2_empty", 64'(empty), 64'd0);
      drain(3'b010, 1);
      chk("t2_valid_after", 64'(acc_req_valid), 64'd0);
      chk("t2_empty_after", 64'(empty), 64'd1);

      // T3 fill FIFO 2, overflow refused, drain in order
      for (int k = 0; k < 4; k++) enq(2, 32'hA0000000 + 32'(k), 8'(10 + k), 1'b1);
      chk("t3_count", 64'(count[2]), 64'd4);
      enq_acc = 2'd2; #1;
      chk("t3_ready_full", 64'(enq_ready), 64'd0);
      enq_acc = 2'd0; #1;
      chk("t3_ready_other", 64'(enq_ready), 64'd1);
      enq(2, 32'hBADBAD00, 8'd14, 1'b0);
      chk("t3_count_hold", 64'(count[2]), 64'd4);
      chk("t3_head_hold", 64'(acc_data[2]), 64'hA0000000);
      drain(3'b100, 4);
      chk("t3_count_drained", 64'(count[2]), 64'd0);

      // T4 full FIFO 0: dequeue accepted, simultaneous enqueue refused
      for (int k = 0; k < 4; k++) enq(0, 32'h40000000 + 32'(k), 8'(20 + k), 1'b1);
      acc_req_ready = 3'b001;
      enq(0, 32'h4F000000, 8'd24, 1'b0);
      acc_req_ready = 3'b000;
      chk("t4_count", 64'(count[0]), 64'd3);
      chk("t4_head", 64'(acc_data[0]), 64'h40000001);
      drain(3'b001, 3);

      // T5 FIFO 1 at count 2: enqueue+dequeue together across pointer wrap
      enq(1, 32'h50000000, 8'd30, 1'b1);
      enq(1, 32'h50000001, 8'd31, 1'b1);
      acc_req_ready = 3'b010;
      for (int k = 0; k < 10; k++) begin
         enq(1, 32'h50000002 + 32'(k), 8'(32 + k), 1'b1);
         chk($sformatf("t5_count_%0d", k), 64'(count[1]), 64'd2);
      end
      // enqueue into FIFO 0 while FIFO 1 dequeues
      enq(0, 32'h60000000, 8'd50, 1'b1);
      chk("t5_cross_count0", 64'(count[0]), 64'd1);
      chk("t5_cross_count1", 64'(count[1]), 64'd1);
      drain(3'b011, 2);
      chk("t5_empty", 64'(empty), 64'd1);

      // T6 reset mid-operation drops everything at once
      enq(0, 32'h70000000, 8'd60, 1'b1);
      enq(2, 32'h70000001, 8'd61, 1'b1);
      enq(0, 32'h70000002, 8'd62, 1'b1);
      chk("t6_valid_pre", 64'(acc_req_valid), 64'b101);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_valid", 64'(acc_req_valid), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);
      chk("t6_data0", 64'(acc_data[0]), 64'd0);
      for (int i = 0; i < N; i++) exp_q[i].delete();
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("t6_count0", 64'(count[0]), 64'd0);
      chk("t6_count2", 64'(count[2]), 64'd0);
      enq(0, 32'h80000000, 8'd70, 1'b1);
      drain(3'b001, 1);

      // final report
      for (int i = 0; i < N; i++) chk($sformatf("q_drained%0d", i), 64'(exp_q[i].size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
